dmem_arbiter: RTL and testbench

//  Shares the single-port DataMemory between two requesters: the core load/store path (Ldr/Str from ControlUnit)
//  and a DMA/loader port used to preload operands and dump results. Arbitrates per cycle (round-robin),

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_rd_tracker.sv | 52 +++++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default widths for the DataMemory arbiter.
package dmem_pkg;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } dmem_req_e;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;

endpackage : dmem_pkg

// File: rtl/dmem_rd_tracker.sv
// One-stage read return tracker: remembers who issued the read presented to
// DataMemory last cycle and steers the returned word to that requester only.
module dmem_rd_tracker
    import dmem_pkg::*;
#(
    parameter int DW = DMEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_issue,
    input  dmem_req_e     rd_issue_owner,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata
);

    logic      rd_pending;
    dmem_req_e rd_owner;

    // Capture a granted read; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= REQ_CORE;
        end else begin
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_owner <= rd_issue_owner;
            end
        end
    end

    // Demux the returned word; the idle side sees zero.
    always_comb begin
        core_rvalid = 1'b0;
        dma_rvalid  = 1'b0;
        core_rdata  = '0;
        dma_rdata   = '0;
        if (reset && rd_pending) begin
            if (rd_owner == REQ_DMA) begin
                dma_rvalid = 1'b1;
                dma_rdata  = mem_rdata;
            end else begin
                core_rvalid = 1'b1;
                core_rdata  = mem_rdata;
            end
        end
    end

endmodule : dmem_rd_tracker

// File: rtl/dmem_arbiter.sv
// Shares single-port DataMemory between the core load/store path and a DMA
// port: zero-latency round-robin grant with a bounded locked DMA burst.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW        = DMEM_AW,
    parameter int DW        = DMEM_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    dmem_req_e     last_owner;
    logic [CW-1:0] burst_cnt;
    logic          locked;
    logic          rd_issue;
    dmem_req_e     rd_issue_owner;

    // A non-zero count means last cycle was a locked DMA beat, so the lock
    // only needs the count plus the current dma_lock and the burst bound.
    always_comb begin
        locked = (burst_cnt != '0) && dma_lock && (burst_cnt < BURST_MAX);
    end

    // Grant decision: single requester wins outright, contention goes to
    // the locked DMA burst or else to whoever did not own the memory last.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (reset) begin
            if (core_req && dma_req) begin
                if (locked || (last_owner == REQ_CORE)) begin
                    dma_gnt = 1'b1;
                end else begin
                    core_gnt = 1'b1;
                end
            end else if (core_req) begin
                core_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
        core_stall = core_req && !core_gnt;
    end

    // Route the granted requester onto the memory port; idle drives zero.
    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_wen   = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dma_gnt) begin
            mem_wen   = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // Round-robin owner and burst length; idle cycles hold the owner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_owner <= REQ_DMA;
            burst_cnt  <= '0;
        end else begin
            if (core_gnt) begin
                last_owner <= REQ_CORE;
            end else if (dma_gnt) begin
                last_owner <= REQ_DMA;
            end
            if (dma_gnt && dma_lock) begin
                if (burst_cnt < BURST_MAX) begin
                    burst_cnt <= burst_cnt + CW'(1);
                end
            end else begin
                burst_cnt <= '0;
            end
        end
    end

    // Read issue information for the return tracker.
    always_comb begin
        rd_issue       = (core_gnt && !core_we) || (dma_gnt && !dma_we);
        rd_issue_owner = dma_gnt ? REQ_DMA : REQ_CORE;
    end

    dmem_rd_tracker #(
        .DW (DW)
    ) u_rd_tracker (
        .clk            (clk),
        .reset          (reset),
        .rd_issue       (rd_issue),
        .rd_issue_owner (rd_issue_owner),
        .mem_rdata      (mem_rdata),
        .core_rvalid    (core_rvalid),
        .core_rdata     (core_rdata),
        .dma_rvalid     (dma_rvalid),
        .dma_rdata      (dma_rdata)
    );

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter with a behavioural DataMemory.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [7:0] dma_addr, dma_wdata, dma_rdata;
    logic       mem_wen;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_lock    (dma_lock),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Single-port synchronous memory, read data one cycle after address.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic       rst;
        logic       creq, cwe;
        logic [7:0] caddr, cwd;
        logic       dreq, dwe, dlock;
        logic [7:0] daddr, dwd;
        logic       e_cg, e_dg, e_wen;
        logic [7:0] e_addr, e_wd;
        logic       e_crv;
        logic [7:0] e_crd;
        logic       e_drv;
        logic [7:0] e_drd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic creq, input logic cwe,
        input logic [7:0] caddr, input logic [7:0] cwd,
        input logic dreq, input logic dwe, input logic dlock,
        input logic [7:0] daddr, input logic [7:0] dwd,
        input logic e_cg, input logic e_dg, input logic e_wen,
        input logic [7:0] e_addr, input logic [7:0] e_wd,
        input logic e_crv, input logic [7:0] e_crd,
        input logic e_drv, input logic [7:0] e_drd);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.daddr = daddr; v.dwd = dwd;
        v.e_cg = e_cg; v.e_dg = e_dg; v.e_wen = e_wen; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_crv = e_crv; v.e_crd = e_crd; v.e_drv = e_drv; v.e_drd = e_drd;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %0h want %0h", idx, name, act, exp);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a + 8'h80);

        // Reset with both requesting: nothing granted, memory idle.
        vecs.push_back(mk(0, 1,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(0, 1,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00));
        // Release: core wins first tie, then strict alternation with reads returning.
        vecs.push_back(mk(1, 1,0,8'h03,8'h00, 1,0,0,8'h04,8'h00, 1,0,0,8'h03,8'h00, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 1,0,8'h03,8'h00, 1,0,0,8'h04,8'h00, 0,1,0,8'h04,8'h00, 1,8'h83, 0,8'h00));
        vecs.push_back(mk(1, 1,0,8'h03,8'h00, 1,0,0,8'h04,8'h00, 1,0,0,8'h03,8'h00, 0,8'h00, 1,8'h84));
        vecs.push_back(mk(1, 1,0,8'h03,8'h00, 1,0,0,8'h04,8'h00, 0,1,0,8'h04,8'h00, 1,8'h83, 0,8'h00));
        // Locked DMA write burst vs waiting core load: C, D x4, C, D x4, C.
        vecs.push_back(mk(1, 1,0,8'h05,8'h00, 1,1,1,8'h10,8'hA5, 1,0,0,8'h05,8'h00, 0,8'h00, 1,8'h84));
        vecs.push_back(mk(1, 1,0,8'h05,8'h00, 1,1,1,8'h10,8'hA5, 0,1,1,8'h10,8'hA5, 1,8'h85, 0,8'h00));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 1,0,8'h05,8'h00, 1,1,1,8'h10,8'hA5, 0,1,1,8'h10,8'hA5, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 1,0,8'h05,8'h00, 1,1,1,8'h10,8'hA5, 1,0,0,8'h05,8'h00, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 1,0,8'h05,8'h00, 1,1,1,8'h10,8'hA5, 0,1,1,8'h10,8'hA5, 1,8'h85, 0,8'h00));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 1,0,8'h05,8'h00, 1,1,1,8'h10,8'hA5, 0,1,1,8'h10,8'hA5, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 1,0,8'h05,8'h00, 1,1,1,8'h10,8'hA5, 1,0,0,8'h05,8'h00, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,8'h85, 0,8'h00));
        // DMA alone may run past MAX_BURST; a new core request then wins at once.
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(1, 0,0,8'h00,8'h00, 1,1,1,8'h10,8'hA5, 0,1,1,8'h10,8'hA5, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 1,0,8'h10,8'h00, 1,1,1,8'h10,8'h11, 1,0,0,8'h10,8'h00, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,8'hA5, 0,8'h00));
        // DMA write then core read of the same address returns the new data.
        vecs.push_back(mk(1, 0,0,8'h00,8'h00, 1,1,0,8'h20,8'h3C, 0,1,1,8'h20,8'h3C, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 1,0,8'h20,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,8'h20,8'h00, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,8'h3C, 0,8'h00));
        // Reset right after a granted load discards the pending read.
        vecs.push_back(mk(1, 1,0,8'h01,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,8'h01,8'h00, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00));
        vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00));
        // Alternating core/DMA loads 0..7, one rvalid per cycle to the issuer.
        for (int k = 0; k < 9; k++) begin
            logic       c_now, d_now, c_prev, d_prev;
            logic [7:0] a, ap;
            a      = 8'(k);
            ap     = 8'(k + 8'h7F);
            c_now  = (k < 8) && (k % 2 == 0);
            d_now  = (k < 8) && (k % 2 == 1);
            c_prev = (k > 0) && (k % 2 == 1);
            d_prev = (k > 0) && (k % 2 == 0);
            vecs.push_back(mk(1, c_now,0,c_now ? a : 8'h00,8'h00, d_now,0,0,d_now ? a : 8'h00,8'h00,
                              c_now, d_now, 0, (k < 8) ? a : 8'h00, 8'h00,
                              c_prev, c_prev ? ap : 8'h00, d_prev, d_prev ? ap : 8'h00));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            core_req   = vecs[i].creq;
            core_we    = vecs[i].cwe;
            core_addr  = vecs[i].caddr;
            core_wdata = vecs[i].cwd;
            dma_req    = vecs[i].dreq;
            dma_we     = vecs[i].dwe;
            dma_lock   = vecs[i].dlock;
            dma_addr   = vecs[i].daddr;
            dma_wdata  = vecs[i].dwd;
            #1;
            chk(i, "core_gnt",    {7'b0, core_gnt},    {7'b0, vecs[i].e_cg});
            chk(i, "dma_gnt",     {7'b0, dma_gnt},     {7'b0, vecs[i].e_dg});
            chk(i, "core_stall",  {7'b0, core_stall},  {7'b0, vecs[i].creq & ~vecs[i].e_cg});
            chk(i, "mem_wen",     {7'b0, mem_wen},     {7'b0, vecs[i].e_wen});
            chk(i, "mem_addr",    mem_addr,            vecs[i].e_addr);
            chk(i, "mem_wdata",   mem_wdata,           vecs[i].e_wd);
            chk(i, "core_rvalid", {7'b0, core_rvalid}, {7'b0, vecs[i].e_crv});
            chk(i, "core_rdata",  core_rdata,          vecs[i].e_crd);
            chk(i, "dma_rvalid",  {7'b0, dma_rvalid},  {7'b0, vecs[i].e_drv});
            chk(i, "dma_rdata",   dma_rdata,           vecs[i].e_drd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dmem_arbiter
